// File: rtl/ram_display_pkg.sv
// Shared definitions for the RAM display stage: FSM states, slot count and
// seven-segment patterns (bit order {g,f,e,d,c,b,a}, active-high).
package ram_display_pkg;

  localparam int NUM_RAM_SLOTS = 5;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_LOAD,
    DISP_SHIFT,
    DISP_DONE
  } disp_state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Map one BCD digit to its segment pattern; non-decimal codes show blank.
  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ram_display_if.sv
// Bundle between the cpu side (RAM words out, display state back) and the
// display stage.
interface ram_display_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIGITS     = 3
);
  logic [DATA_WIDTH-1:0] ram0x00;
  logic [DATA_WIDTH-1:0] ram0x01;
  logic [DATA_WIDTH-1:0] ram0x02;
  logic [DATA_WIDTH-1:0] ram0x03;
  logic [DATA_WIDTH-1:0] ram0x04;
  logic [2:0]            slot;
  logic [DIGITS*7-1:0]   seg;
  logic                  valid;

  modport master (
    output ram0x00, ram0x01, ram0x02, ram0x03, ram0x04,
    input  slot, seg, valid
  );

  modport slave (
    input  ram0x00, ram0x01, ram0x02, ram0x03, ram0x04,
    output slot, seg, valid
  );
endinterface

// File: rtl/ram_display_seg7_decode.sv
// One seven-segment digit: BCD in, pattern out, forced dark when blanked.
module seg7_decode
  import ram_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup with blank override.
  always_comb begin
    seg = blank ? SEG_BLANK : seg_of(bcd);
  end

endmodule

// File: rtl/ram_display.sv
// Shows one of five RAM words in decimal. A synchronized push-button steps the
// slot; a double-dabble FSM converts the selected word continuously.
module ram_display
  import ram_display_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIGITS     = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          next,
  ram_display_if.slave  bus
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  sync1, sync2, sync3;
  logic                  inc;
  logic [2:0]            slot;
  logic [DATA_WIDTH-1:0] sel_word;
  disp_state_t           state;
  logic [DATA_WIDTH-1:0] bin;
  logic [BCD_W-1:0]      bcd;
  logic [BCD_W-1:0]      bcd_adj;
  logic [CNT_W-1:0]      cnt;
  logic [BCD_W-1:0]      disp;
  logic                  valid;
  logic [DIGITS-1:0]     blank;
  logic [DIGITS*7-1:0]   seg_w;

  // Two-flop synchronizer plus one delay flop for the rising-edge detector.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= next;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign inc = sync2 & ~sync3;

  // Slot counter, wraps after the last RAM word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot <= '0;
    end else if (inc) begin
      slot <= (slot == 3'(NUM_RAM_SLOTS - 1)) ? 3'd0 : slot + 3'd1;
    end
  end

  // Select the word for the current slot.
  // NOTE: default assignment up front keeps this purely combinational.
  always_comb begin
    sel_word = bus.ram0x00;
    case (slot)
      3'd1:    sel_word = bus.ram0x01;
      3'd2:    sel_word = bus.ram0x02;
      3'd3:    sel_word = bus.ram0x03;
      3'd4:    sel_word = bus.ram0x04;
      default: sel_word = bus.ram0x00;
    endcase
  end

  // Double-dabble correction: add 3 to every nibble of 5 or more.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // Conversion FSM; a slot step restarts it and suppresses a pending latch.
  // NOTE: the display register is reset so a fresh start never shows stale digits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= DISP_IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      disp  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        DISP_IDLE: state <= DISP_LOAD;
        DISP_LOAD: begin
          bin   <= sel_word;
          bcd   <= '0;
          cnt   <= '0;
          state <= DISP_SHIFT;
        end
        DISP_SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_WIDTH - 1)) state <= DISP_DONE;
        end
        DISP_DONE: begin
          if (!inc) begin
            disp  <= bcd;
            valid <= 1'b1;
          end
          state <= DISP_LOAD;
        end
        default: state <= DISP_IDLE;
      endcase
      if (inc && state != DISP_IDLE) state <= DISP_LOAD;
    end
  end

  // Leading-zero blanking; everything is dark until the first latch.
  always_comb begin
    logic higher_zero;
    logic zero_run;
    blank       = '0;
    higher_zero = 1'b1;
    zero_run    = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run    = higher_zero && (disp[4*k +: 4] == 4'd0);
      blank[k]    = !valid || ((k != 0) && zero_run);
      higher_zero = zero_run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decode u_dec (
      .bcd   (disp[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_w[7*g +: 7])
    );
  end

  assign bus.seg   = seg_w;
  assign bus.slot  = slot;
  assign bus.valid = valid;

endmodule

// File: tb/tb_ram_display.sv
// Directed bench for ram_display: reset/first latch, wide values, button
// stepping and latency, abort on slot change, and mid-conversion reset.
module tb_ram_display;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic next_btn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ram_display_if #(.DATA_WIDTH(8), .DIGITS(3)) bus ();

  ram_display #(.DATA_WIDTH(8), .DIGITS(3)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .next (next_btn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and sample 1 ns later.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b0111111;
      1: pat = 7'b0000110;
      2: pat = 7'b1011011;
      3: pat = 7'b1001111;
      4: pat = 7'b1100110;
      5: pat = 7'b1101101;
      6: pat = 7'b1111101;
      7: pat = 7'b0000111;
      8: pat = 7'b1111111;
      default: pat = 7'b1101111;
    endcase
  endfunction

  // Expected three-digit pattern with leading-zero blanking.
  function automatic logic [20:0] exp_seg(input int v);
    int h, t, u;
    logic [6:0] ph, pt;
    h  = v / 100;
    t  = (v / 10) % 10;
    u  = v % 10;
    ph = (h == 0) ? 7'b0 : pat(h);
    pt = (h == 0 && t == 0) ? 7'b0 : pat(t);
    exp_seg = {ph, pt, pat(u)};
  endfunction

  task automatic wait_seg(input logic [20:0] exp, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.seg !== exp && n < budget) begin
      step(1);
      n++;
    end
    check(tag, bus.seg, exp);
  endtask

  // One press: check the slot holds for two edges and steps on the third.
  task automatic press(input logic [2:0] old_slot, input logic [2:0] new_slot, input int hold);
    next_btn = 1'b1;
    step(2);
    check("btn_latency_hold", bus.slot, old_slot);
    step(1);
    check("btn_step", bus.slot, new_slot);
    step(hold);
    check("btn_held_once", bus.slot, new_slot);
    next_btn = 1'b0;
    step(4);
  endtask

  initial begin
    bit saw200;
    bus.ram0x00 = 8'd0;
    bus.ram0x01 = 8'd0;
    bus.ram0x02 = 8'd0;
    bus.ram0x03 = 8'd0;
    bus.ram0x04 = 8'd0;

    // Reset and first latch at edge 11.
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", bus.seg, 21'd0);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_slot", bus.slot, 3'd0);
    rstn = 1'b1;
    step(10);
    check("edge10_valid", bus.valid, 1'b0);
    check("edge10_seg", bus.seg, 21'd0);
    step(1);
    check("edge11_valid", bus.valid, 1'b1);
    check("edge11_seg", bus.seg, exp_seg(0));

    // Full-scale value.
    bus.ram0x00 = 8'd255;
    wait_seg(exp_seg(255), 10, "show_255");

    // Two long presses land on slot 2 showing 7.
    bus.ram0x02 = 8'd7;
    press(3'd0, 3'd1, 17);
    press(3'd1, 3'd2, 17);
    wait_seg(exp_seg(7), 12, "show_7");
    check("show_7_exact", bus.seg, {7'b0, 7'b0, 7'b0000111});

    // Remaining presses complete the 1,2,3,4,0 walk.
    press(3'd2, 3'd3, 2);
    press(3'd3, 3'd4, 2);
    press(3'd4, 3'd0, 2);

    // Abort: slot 0 returns to 255, then 200 is loaded and aborted mid-shift.
    bus.ram0x01 = 8'd42;
    wait_seg(exp_seg(255), 24, "back_255");
    bus.ram0x00 = 8'd200;
    next_btn = 1'b1;
    step(3);
    check("abort_slot", bus.slot, 3'd1);
    saw200 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (bus.seg === exp_seg(200)) saw200 = 1'b1;
      if (i == 9) check("abort_keeps_old", bus.seg, exp_seg(255));
    end
    check("abort_no_200", saw200, 1'b0);
    check("abort_show_42", bus.seg, {7'b0, 7'b1100110, 7'b1011011});
    next_btn = 1'b0;
    step(3);

    // Reset in the middle of a conversion after showing 99.
    bus.ram0x01 = 8'd99;
    wait_seg(exp_seg(99), 24, "show_99");
    step(3);
    rstn = 1'b0;
    #1;
    check("midrst_seg", bus.seg, 21'd0);
    check("midrst_slot", bus.slot, 3'd0);
    check("midrst_valid", bus.valid, 1'b0);
    step(2);
    rstn = 1'b1;
    step(10);
    check("resume_valid_low", bus.valid, 1'b0);
    step(1);
    check("resume_valid", bus.valid, 1'b1);
    check("resume_seg_200", bus.seg, exp_seg(200));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
